// File: rtl/not64x1.sv
// not64x1 -- 64-bit bitwise inverter for the sequential Y86 ALU logic path.
//
// Purpose:
//   Combinational result ans = ~a (equivalently -a - 1 in two's complement),
//   plus a one-cycle registered copy with a valid strobe and Y86-style
//   condition flags for the sequential stage logic.
//
// Ports:
//   clk       in   1      rising-edge clock for the registered stage
//   rst_n     in   1      asynchronous reset, active-low
//   a         in   WIDTH  signed operand
//   in_valid  in   1      capture strobe for the registered stage
//   ans       out  WIDTH  combinational result, ~a (no clock/reset dependency)
//   ans_q     out  WIDTH  registered result
//   out_valid out  1      high for one cycle after each capture
//   zf        out  1      registered zero flag   (result == 0)
//   sf        out  1      registered sign flag   (result MSB)
//   of        out  1      registered overflow flag (always 0 for inversion)
//   pf        out  1      registered parity flag, only with NOT64X1_PARITY_EN
//
// Configuration:
//   NOT64X1_PARITY_EN -- when defined, adds the pf output: 1 when the
//   captured result holds an even number of ones.
//
// Only WIDTH = 64 is supported.

// Single-bit inverter cell; one instance per datapath bit.
module not64x1_bit (
  input  logic a,
  output logic y
);
  assign y = ~a;
endmodule

module not64x1 #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   a,
  input  logic               in_valid,
  output logic [WIDTH-1:0]   ans,
  output logic [WIDTH-1:0]   ans_q,
  output logic               out_valid,
  output logic               zf,
  output logic               sf,
  output logic               of
`ifdef NOT64X1_PARITY_EN
  ,
  output logic               pf
`endif
);

  // Combinational inversion, one cell per bit. Being a pure gate path it
  // passes X/Z on an input bit through as X on the matching ans bit and keeps
  // working while rst_n is low.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_inv
    not64x1_bit u_bit (
      .a (a[gi]),
      .y (ans[gi])
    );
  end

  // Registered stage: captures the combinational result when in_valid is
  // high; result and flags hold otherwise, while out_valid drops back to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ans_q     <= '0;
      out_valid <= 1'b0;
      zf        <= 1'b0;
      sf        <= 1'b0;
      of        <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        ans_q <= ans;
        zf    <= (ans == '0);
        sf    <= ans[WIDTH-1];
        // Inversion maps every 64-bit value to another 64-bit value, so it
        // can never overflow.
        of    <= 1'b0;
      end
    end
  end

`ifdef NOT64X1_PARITY_EN
  // Even parity of the result: XNOR-reduce gives 1 for an even count of ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pf <= 1'b0;
    end else if (in_valid) begin
      pf <= ~^ans;
    end
  end
`endif

endmodule

// File: tb/tb_not64x1.sv
// Self-checking bench for not64x1: table-driven capture vectors plus
// hand-written sequences for reset, hold, back-to-back and no-clock cases.
module tb_not64x1;

  logic        clk;
  logic        rst_n;
  logic [63:0] a;
  logic        in_valid;
  logic [63:0] ans;
  logic [63:0] ans_q;
  logic        out_valid;
  logic        zf;
  logic        sf;
  logic        of;
`ifdef NOT64X1_PARITY_EN
  logic        pf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  not64x1 #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .in_valid  (in_valid),
    .ans       (ans),
    .ans_q     (ans_q),
    .out_valid (out_valid),
    .zf        (zf),
    .sf        (sf),
    .of        (of)
`ifdef NOT64X1_PARITY_EN
    ,
    .pf        (pf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required < 100000", $time);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [63:0] a;
    logic [63:0] exp_ans;
    logic        exp_zf;
    logic        exp_sf;
    logic        exp_pf;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] required);
    n_checks++;
    if (actual !== required) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, actual, required);
    end
  endtask

  initial begin
    // {a, expected ans, zf, sf, pf}
    vecs[0] = '{64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{64'h0000_0000_0000_0009, 64'hFFFF_FFFF_FFFF_FFF6, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{64'h0000_0000_0000_000B, 64'hFFFF_FFFF_FFFF_FFF4, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFF5, 64'h0000_0000_0000_000A, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{64'h0000_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1'b1, 1'b1};

    rst_n    = 1'b0;
    a        = 64'h0;
    in_valid = 1'b0;

    // Reset state, and combinational path alive while rst_n is low.
    #12;
    check("reset ans_q", ans_q, 64'h0);
    check("reset out_valid", {63'h0, out_valid}, 64'h0);
    check("reset zf", {63'h0, zf}, 64'h0);
    check("reset sf", {63'h0, sf}, 64'h0);
    check("reset of", {63'h0, of}, 64'h0);
`ifdef NOT64X1_PARITY_EN
    check("reset pf", {63'h0, pf}, 64'h0);
`endif
    a = 64'h0000_0000_0000_0009;
    #1;
    check("ans in reset", ans, 64'hFFFF_FFFF_FFFF_FFF6);
    $display("reset: ans_q=%h out_valid=%b ans=%h", ans_q, out_valid, ans);

    // No-clock combinational sequence, 20 ns apart.
    a = 64'h0000_0000_0000_0009;
    #20;
    check("noclk ans 9", ans, 64'hFFFF_FFFF_FFFF_FFF6);
    a = 64'h0000_0000_0000_000B;
    #20;
    check("noclk ans B", ans, 64'hFFFF_FFFF_FFFF_FFF4);
    $display("noclk: a=%h ans=%h", a, ans);

    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table-driven capture: combinational check, capture cycle, then hold.
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      a        = vecs[i].a;
      in_valid = 1'b1;
      #1;
      check($sformatf("v%0d ans", i), ans, vecs[i].exp_ans);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check($sformatf("v%0d ans_q", i), ans_q, vecs[i].exp_ans);
      check($sformatf("v%0d zf", i), {63'h0, zf}, {63'h0, vecs[i].exp_zf});
      check($sformatf("v%0d sf", i), {63'h0, sf}, {63'h0, vecs[i].exp_sf});
      check($sformatf("v%0d of", i), {63'h0, of}, 64'h0);
      check($sformatf("v%0d out_valid", i), {63'h0, out_valid}, 64'h1);
`ifdef NOT64X1_PARITY_EN
      check($sformatf("v%0d pf", i), {63'h0, pf}, {63'h0, vecs[i].exp_pf});
`endif
      // Change a without capturing: registered state must hold.
      a = ~vecs[i].a ^ 64'h1;
      @(posedge clk);
      #1;
      check($sformatf("v%0d hold ans_q", i), ans_q, vecs[i].exp_ans);
      check($sformatf("v%0d hold zf", i), {63'h0, zf}, {63'h0, vecs[i].exp_zf});
      check($sformatf("v%0d out_valid drop", i), {63'h0, out_valid}, 64'h0);
      $display("vec %0d: a=%h ans_q=%h zf=%b sf=%b of=%b out_valid(next)=%b",
               i, vecs[i].a, ans_q, zf, sf, of, out_valid);
    end

    // Back-to-back captures: out_valid stays high, ans_q tracks each cycle.
    a        = 64'h0000_0000_0000_0001;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("b2b0 ans_q", ans_q, 64'hFFFF_FFFF_FFFF_FFFE);
    check("b2b0 out_valid", {63'h0, out_valid}, 64'h1);
    a = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk);
    #1;
    check("b2b1 ans_q", ans_q, 64'h0);
    check("b2b1 zf", {63'h0, zf}, 64'h1);
    check("b2b1 out_valid", {63'h0, out_valid}, 64'h1);
    in_valid = 1'b0;
    $display("b2b: ans_q=%h zf=%b out_valid=%b", ans_q, zf, out_valid);

    // Asynchronous reset between clock edges clears registers at once.
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst ans_q", ans_q, 64'h0);
    check("async rst zf", {63'h0, zf}, 64'h0);
    check("async rst out_valid", {63'h0, out_valid}, 64'h0);
    check("async rst sf", {63'h0, sf}, 64'h0);
    check("async rst ans", ans, 64'h0);
    $display("async reset: ans_q=%h zf=%b out_valid=%b ans=%h", ans_q, zf, out_valid, ans);
    #1;
    rst_n = 1'b1;

`ifdef NOT64X1_PARITY_EN
    // Parity: a=1 gives 63 ones in the result.
    @(posedge clk);
    #1;
    a        = 64'h1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("pf a=1", {63'h0, pf}, 64'h0);
    $display("parity: a=%h pf=%b", a, pf);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
